sevenseg_scanner: RTL and testbench



---
 rtl/sevenseg_pkg.sv | 26 ++
 rtl/sevenseg_scanner_hex7seg.sv | 14 +
 rtl/sevenseg_scanner.sv | 176 +++++++++++++++++
 tb/tb_sevenseg_scanner.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the 7-segment scanner: FSM state encoding
// and the active-low hex segment table, bit order {G,F,E,D,C,B,A}.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  // All cathodes released (segment dark).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry i is the active-low pattern for hex value i.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,  // F E D C
    7'h03, 7'h08, 7'h10, 7'h00,  // B A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,  // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40   // 3 2 1 0
  };

  function automatic logic [6:0] seg_lookup(input logic [3:0] val);
    return SEG_TABLE[val];
  endfunction

endpackage

// File: rtl/sevenseg_scanner_hex7seg.sv
// Combinational hex-to-segment decoder, active-low outputs.
module hex7seg_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  // Pure table lookup; no state.
  always_comb begin
    seg_n = seg_lookup(hex);
  end

endmodule

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Each digit slot is BLANK (all anodes off, suppresses ghosting) followed by
// DRIVE. Writes land in a shadow register and are committed to the displayed
// value only at the frame boundary, so a frame never mixes old and new data.
module sevenseg_scanner
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS  = 8,
  parameter int PRESCALE = 100000,
  parameter int DEADTIME = 500
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ENABLE,
  input  logic [4*NDIGITS-1:0]   DIN,
  input  logic                   DIN_WE,
  input  logic [NDIGITS-1:0]     DP_EN,
  input  logic                   BLANK_LZ,
  output logic [NDIGITS-1:0]     AN,
  output logic [6:0]             SEG,
  output logic                   DP,
  output logic                   FRAME_DONE,
  output logic                   PENDING
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int DIG_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEADTIME - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NDIGITS - 1);

  // Scan state
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIG_W-1:0]     digit_q, digit_d;

  // Data path
  logic [4*NDIGITS-1:0] shadow_q, shadow_d;
  logic [4*NDIGITS-1:0] display_q, display_d;
  logic                 pending_q, pending_d;

  // Registered pins
  logic [NDIGITS-1:0]   an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic                 frame_done_q, frame_done_d;

  logic                 boundary;
  logic                 commit_ok;
  logic [3:0]           cur_nib;
  logic [6:0]           dec_seg;
  logic [NDIGITS-1:0]   upper_zero;
  logic                 lz_blank;

  hex7seg_decoder u_dec (
    .hex   (cur_nib),
    .seg_n (dec_seg)
  );

  // Scan sequencing: slot counter, digit index and the frame-boundary strobe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digit_d  = digit_q;
    boundary = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        digit_d = '0;
      end
      ST_BLANK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DEAD_LAST) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (cnt_q == PRE_LAST) begin
          state_d  = ST_BLANK;
          cnt_d    = '0;
          boundary = (digit_q == DIG_LAST);
          digit_d  = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Disable wins over everything and clears the scan position.
    if (!ENABLE) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      digit_d  = '0;
      boundary = 1'b0;
    end
  end

  // Shadow/commit: writes commit at a frame boundary or whenever the scan is
  // idle (no frame to tear). A same-cycle write bypasses the shadow.
  always_comb begin
    shadow_d  = shadow_q;
    display_d = display_q;
    pending_d = pending_q;
    commit_ok = boundary || (state_q == ST_IDLE);
    if (commit_ok) begin
      if (DIN_WE) begin
        display_d = DIN;
        pending_d = 1'b0;
      end else if (pending_q) begin
        display_d = shadow_q;
        pending_d = 1'b0;
      end
    end else if (DIN_WE) begin
      shadow_d  = DIN;
      pending_d = 1'b1;
    end
  end

  // upper_zero[d]: display nibbles d..NDIGITS-1 are all zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[NDIGITS-1] = (display_q[4*(NDIGITS-1) +: 4] == 4'h0);
    for (int d = NDIGITS - 2; d >= 0; d--) begin
      upper_zero[d] = upper_zero[d+1] && (display_q[4*d +: 4] == 4'h0);
    end
  end

  // Pin values for the current slot; digit 0 is never leading-zero blanked.
  always_comb begin
    cur_nib      = display_q[4*digit_q +: 4];
    lz_blank     = BLANK_LZ && (digit_q != '0) && upper_zero[digit_q];
    an_d         = '1;
    seg_d        = SEG_OFF;
    dp_d         = 1'b1;
    frame_done_d = boundary;
    if (state_q == ST_DRIVE) begin
      an_d  = ~(NDIGITS'(1) << digit_q);
      seg_d = lz_blank ? SEG_OFF : dec_seg;
      dp_d  = ~DP_EN[digit_q];
    end
  end

  // Single register bank for FSM, data path and output pins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      digit_q      <= '0;
      shadow_q     <= '0;
      display_q    <= '0;
      pending_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign DP         = dp_q;
  assign FRAME_DONE = frame_done_q;
  assign PENDING    = pending_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Directed bench for sevenseg_scanner with NDIGITS=8, PRESCALE=8, DEADTIME=2.
// Each scenario is a list of input events and expected-output ranges indexed
// by cycle k; outputs "at k" are those visible just before posedge k.
module tb_sevenseg_scanner;

  logic        CLK = 1'b0;
  logic        RST, ENABLE, DIN_WE, BLANK_LZ;
  logic [31:0] DIN;
  logic [7:0]  DP_EN;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP, FRAME_DONE, PENDING;

  int n_checks = 0;
  int n_pass   = 0;

  sevenseg_scanner #(.NDIGITS(8), .PRESCALE(8), .DEADTIME(2)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .DIN(DIN), .DIN_WE(DIN_WE),
    .DP_EN(DP_EN), .BLANK_LZ(BLANK_LZ), .AN(AN), .SEG(SEG), .DP(DP),
    .FRAME_DONE(FRAME_DONE), .PENDING(PENDING)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          k;
    logic        rst, en, we;
    logic [31:0] din;
    logic        lz;
    logic [7:0]  dpen;
  } ev_t;

  typedef struct {
    int         k0, k1;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp, fd, pend;
  } vec_t;

  ev_t  evq[$];
  vec_t vq[$];

  function automatic void ev(int k, logic rst, logic en, logic we,
                             logic [31:0] din, logic lz, logic [7:0] dpen);
    ev_t e;
    e.k = k; e.rst = rst; e.en = en; e.we = we; e.din = din; e.lz = lz; e.dpen = dpen;
    evq.push_back(e);
  endfunction

  function automatic void vx(int k0, int k1, logic [7:0] an, logic [6:0] seg,
                             logic dp, logic fd, logic pend);
    vec_t v;
    v.k0 = k0; v.k1 = k1; v.an = an; v.seg = seg; v.dp = dp; v.fd = fd; v.pend = pend;
    vq.push_back(v);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut(input logic en);
    RST = 1'b1; ENABLE = en; DIN_WE = 1'b0; DIN = '0; BLANK_LZ = 1'b0; DP_EN = '0;
    tick();
    tick();
  endtask

  task automatic run(input string name, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      foreach (evq[i]) begin
        if (evq[i].k == k) begin
          RST = evq[i].rst; ENABLE = evq[i].en; DIN_WE = evq[i].we;
          DIN = evq[i].din; BLANK_LZ = evq[i].lz; DP_EN = evq[i].dpen;
        end
      end
      foreach (vq[i]) begin
        if (k >= vq[i].k0 && k <= vq[i].k1) begin
          n_checks++;
          if ({AN, SEG, DP, FRAME_DONE, PENDING} ===
              {vq[i].an, vq[i].seg, vq[i].dp, vq[i].fd, vq[i].pend}) begin
            n_pass++;
          end else begin
            $display("FAIL %s k=%0d: got AN=%h SEG=%h DP=%b FD=%b PEND=%b, want AN=%h SEG=%h DP=%b FD=%b PEND=%b",
                     name, k, AN, SEG, DP, FRAME_DONE, PENDING,
                     vq[i].an, vq[i].seg, vq[i].dp, vq[i].fd, vq[i].pend);
          end
        end
      end
      tick();
    end
    evq.delete();
    vq.delete();
  endtask

  initial begin
    // Reset and plain scan of an all-zero value.
    reset_dut(1'b1);
    ev(0, 0, 1, 0, 32'h0, 0, 8'h00);
    vx(0, 2,   8'hFF, 7'h7F, 1, 0, 0);
    vx(3, 8,   8'hFE, 7'h40, 1, 0, 0);
    vx(9, 10,  8'hFF, 7'h7F, 1, 0, 0);
    vx(11, 16, 8'hFD, 7'h40, 1, 0, 0);
    vx(59, 63, 8'h7F, 7'h40, 1, 0, 0);
    vx(64, 64, 8'h7F, 7'h40, 1, 1, 0);
    vx(65, 66, 8'hFF, 7'h7F, 1, 0, 0);
    run("scan", 67);

    // Tear-free update: write mid-frame, visible only next frame.
    reset_dut(1'b1);
    ev(0,  0, 1, 0, 32'h0,    0, 8'h00);
    ev(20, 0, 1, 1, 32'h00F1, 0, 8'h00);
    ev(21, 0, 1, 0, 32'h00F1, 0, 8'h00);
    vx(0, 2,   8'hFF, 7'h7F, 1, 0, 0);
    vx(3, 8,   8'hFE, 7'h40, 1, 0, 0);
    vx(20, 20, 8'hFB, 7'h40, 1, 0, 0);
    vx(21, 24, 8'hFB, 7'h40, 1, 0, 1);
    vx(25, 26, 8'hFF, 7'h7F, 1, 0, 1);
    vx(27, 32, 8'hF7, 7'h40, 1, 0, 1);
    vx(59, 63, 8'h7F, 7'h40, 1, 0, 1);
    vx(64, 64, 8'h7F, 7'h40, 1, 1, 0);
    vx(65, 66, 8'hFF, 7'h7F, 1, 0, 0);
    vx(67, 72, 8'hFE, 7'h79, 1, 0, 0);
    vx(73, 74, 8'hFF, 7'h7F, 1, 0, 0);
    vx(75, 80, 8'hFD, 7'h0E, 1, 0, 0);
    vx(83, 88, 8'hFB, 7'h40, 1, 0, 0);
    run("tearfree", 89);

    // Last write wins; boundary-cycle write bypasses the shadow.
    reset_dut(1'b1);
    ev(0,   0, 1, 0, 32'h0, 0, 8'h00);
    ev(30,  0, 1, 1, 32'h1, 0, 8'h00);
    ev(31,  0, 1, 0, 32'h1, 0, 8'h00);
    ev(63,  0, 1, 1, 32'h8, 0, 8'h00);
    ev(64,  0, 1, 0, 32'h8, 0, 8'h00);
    ev(104, 0, 1, 1, 32'h2, 0, 8'h00);
    ev(105, 0, 1, 0, 32'h2, 0, 8'h00);
    vx(31, 31,   8'hF7, 7'h40, 1, 0, 1);
    vx(63, 63,   8'h7F, 7'h40, 1, 0, 1);
    vx(64, 64,   8'h7F, 7'h40, 1, 1, 0);
    vx(67, 72,   8'hFE, 7'h00, 1, 0, 0);
    vx(75, 80,   8'hFD, 7'h40, 1, 0, 0);
    vx(105, 105, 8'hFF, 7'h7F, 1, 0, 1);
    vx(128, 128, 8'h7F, 7'h40, 1, 1, 0);
    vx(131, 136, 8'hFE, 7'h24, 1, 0, 0);
    run("bypass", 137);

    // Leading-zero blanking and DP; value loaded while idle, then enabled.
    reset_dut(1'b0);
    ev(0, 0, 0, 0, 32'h0,   1, 8'h08);
    ev(2, 0, 0, 1, 32'h105, 1, 8'h08);
    ev(3, 0, 0, 0, 32'h105, 1, 8'h08);
    ev(4, 0, 1, 0, 32'h105, 1, 8'h08);
    vx(0, 7,   8'hFF, 7'h7F, 1, 0, 0);
    vx(8, 13,  8'hFE, 7'h12, 1, 0, 0);
    vx(14, 15, 8'hFF, 7'h7F, 1, 0, 0);
    vx(16, 21, 8'hFD, 7'h40, 1, 0, 0);
    vx(24, 29, 8'hFB, 7'h79, 1, 0, 0);
    vx(30, 31, 8'hFF, 7'h7F, 1, 0, 0);
    vx(32, 37, 8'hF7, 7'h7F, 0, 0, 0);
    vx(40, 45, 8'hEF, 7'h7F, 1, 0, 0);
    vx(64, 68, 8'h7F, 7'h7F, 1, 0, 0);
    vx(69, 69, 8'h7F, 7'h7F, 1, 1, 0);
    run("lzblank", 70);

    // ENABLE dropped mid-DRIVE of digit 5, then re-enabled.
    reset_dut(1'b1);
    ev(0,  0, 1, 0, 32'h0, 0, 8'h00);
    ev(45, 0, 0, 0, 32'h0, 0, 8'h00);
    ev(50, 0, 1, 0, 32'h0, 0, 8'h00);
    vx(43, 46,   8'hDF, 7'h40, 1, 0, 0);
    vx(47, 53,   8'hFF, 7'h7F, 1, 0, 0);
    vx(54, 59,   8'hFE, 7'h40, 1, 0, 0);
    vx(60, 61,   8'hFF, 7'h7F, 1, 0, 0);
    vx(62, 64,   8'hFD, 7'h40, 1, 0, 0);
    vx(115, 115, 8'h7F, 7'h40, 1, 1, 0);
    run("enable", 116);

    // Reset mid-frame discards a pending write.
    reset_dut(1'b1);
    ev(0,  0, 1, 0, 32'h0, 0, 8'h00);
    ev(20, 0, 1, 1, 32'h3, 0, 8'h00);
    ev(21, 0, 1, 0, 32'h3, 0, 8'h00);
    ev(40, 1, 1, 0, 32'h3, 0, 8'h00);
    ev(41, 0, 1, 0, 32'h3, 0, 8'h00);
    vx(21, 21,   8'hFB, 7'h40, 1, 0, 1);
    vx(40, 40,   8'hEF, 7'h40, 1, 0, 1);
    vx(41, 43,   8'hFF, 7'h7F, 1, 0, 0);
    vx(44, 49,   8'hFE, 7'h40, 1, 0, 0);
    vx(105, 105, 8'h7F, 7'h40, 1, 1, 0);
    vx(108, 113, 8'hFE, 7'h40, 1, 0, 0);
    run("midreset", 114);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
